// File: rtl/clock_pkg.sv
// Shared encodings and limits for the alarm-clock blocks: mode-FSM states,
// time-set field codes and field range limits.
package clock_pkg;

  // Mode-FSM state encodings (MODE_SET_TIME is the default SET_STATE).
  localparam logic [2:0] MODE_NORMAL    = 3'b000;
  localparam logic [2:0] MODE_SET_ALARM = 3'b001;
  localparam logic [2:0] MODE_SET_TIME  = 3'b010;
  localparam logic [2:0] MODE_ALARM_ON  = 3'b011;

  localparam logic [1:0] FLD_SEC  = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_HR   = 2'd2;
  localparam logic [1:0] FLD_IDLE = 2'd3;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_SEC  = 2'd1,
    SEQ_MIN  = 2'd2,
    SEQ_HR   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/range_clamp.sv
// Combinational saturating range check: values above i_max (and, optionally,
// zero) are replaced by i_max, and o_over reports that a replacement happened.
module range_clamp #(
  parameter int IN_W = 6
) (
  input  logic [IN_W-1:0] i_value,
  input  logic [IN_W-1:0] i_max,
  input  logic            i_zero_to_max,
  output logic [IN_W-1:0] o_value,
  output logic            o_over
);

  logic w_zero_hit;

  // 12h hours have no zero; a zero entry means "twelve".
  assign w_zero_hit = i_zero_to_max && (i_value == '0);
  assign o_over     = (i_value > i_max) || w_zero_hit;
  assign o_value    = o_over ? i_max : i_value;

endmodule

// File: rtl/set_time_seq.sv
// Clocked time-set sequencer: steps seconds, minutes, hours on each next-button
// press, clamps each entry and commits all three fields atomically with a load pulse.
module set_time_seq
  import clock_pkg::*;
#(
  parameter logic [2:0] SET_STATE = MODE_SET_TIME,
  parameter int         IN_W      = 6,
  parameter int         HR_W      = 5,
  parameter bit         MODE_12H  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      state,
  input  logic            nxt_but,
  input  logic [IN_W-1:0] in_time,
  output logic [5:0]      seconds,
  output logic [5:0]      minutes,
  output logic [HR_W-1:0] hours,
  output logic [1:0]      field,
  output logic            load,
  output logic            clamped
);

  // Compare wide enough to hold the largest limit even for narrow switch banks.
  localparam int CMP_W = (IN_W > 6) ? IN_W : 6;
  localparam logic [HR_W-1:0] HR_RST = MODE_12H ? HR_W'(HR12_MAX) : '0;

  seq_state_e      r_state;
  logic            r_nxt_q;
  logic [5:0]      r_stg_sec;
  logic [5:0]      r_stg_min;
  logic [5:0]      r_seconds;
  logic [5:0]      r_minutes;
  logic [HR_W-1:0] r_hours;
  logic [1:0]      r_field;
  logic            r_load;
  logic            r_clamped;

  logic             w_press;
  logic             w_abort;
  logic [CMP_W-1:0] w_raw;
  logic [CMP_W-1:0] w_max;
  logic             w_zero_to_max;
  logic [CMP_W-1:0] w_val;
  logic             w_over;

  assign w_press = nxt_but && !r_nxt_q;
  assign w_abort = (state != SET_STATE);
  assign w_raw   = CMP_W'(in_time);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_max         = CMP_W'(SEC_MAX);
    w_zero_to_max = 1'b0;
    case (r_state)
      SEQ_MIN: w_max = CMP_W'(MIN_MAX);
      SEQ_HR: begin
        if (MODE_12H) begin
          w_max         = CMP_W'(HR12_MAX);
          w_zero_to_max = 1'b1;
        end else begin
          w_max = CMP_W'(HR24_MAX);
        end
      end
      default: ;
    endcase
  end

  range_clamp #(
    .IN_W (CMP_W)
  ) u_clamp (
    .i_value       (w_raw),
    .i_max         (w_max),
    .i_zero_to_max (w_zero_to_max),
    .o_value       (w_val),
    .o_over        (w_over)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEQ_IDLE;
      r_nxt_q   <= 1'b0;
      r_stg_sec <= '0;
      r_stg_min <= '0;
      r_seconds <= '0;
      r_minutes <= '0;
      r_hours   <= HR_RST;
      r_field   <= FLD_IDLE;
      r_load    <= 1'b0;
      r_clamped <= 1'b0;
    end else begin
      r_nxt_q <= nxt_but;
      r_load  <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (!w_abort) begin
            r_state   <= SEQ_SEC;
            r_field   <= FLD_SEC;
            r_stg_sec <= '0;
            r_stg_min <= '0;
            r_clamped <= 1'b0;
          end
        end
        SEQ_SEC: begin
          if (w_abort) begin
            r_state <= SEQ_IDLE;
            r_field <= FLD_IDLE;
          end else if (w_press) begin
            r_stg_sec <= 6'(w_val);
            r_clamped <= r_clamped || w_over;
            r_state   <= SEQ_MIN;
            r_field   <= FLD_MIN;
          end
        end
        SEQ_MIN: begin
          if (w_abort) begin
            r_state <= SEQ_IDLE;
            r_field <= FLD_IDLE;
          end else if (w_press) begin
            r_stg_min <= 6'(w_val);
            r_clamped <= r_clamped || w_over;
            r_state   <= SEQ_HR;
            r_field   <= FLD_HR;
          end
        end
        SEQ_HR: begin
          if (w_abort) begin
            r_state <= SEQ_IDLE;
            r_field <= FLD_IDLE;
          end else if (w_press) begin
            // Hours go straight from the clamp so all three fields land together.
            r_seconds <= r_stg_sec;
            r_minutes <= r_stg_min;
            r_hours   <= HR_W'(w_val);
            r_clamped <= r_clamped || w_over;
            r_load    <= 1'b1;
            r_state   <= SEQ_IDLE;
            r_field   <= FLD_IDLE;
          end
        end
        default: begin
          r_state <= SEQ_IDLE;
          r_field <= FLD_IDLE;
        end
      endcase
    end
  end

  assign seconds = r_seconds;
  assign minutes = r_minutes;
  assign hours   = r_hours;
  assign field   = r_field;
  assign load    = r_load;
  assign clamped = r_clamped;

endmodule

// File: tb/tb_set_time_seq.sv
// Directed bench for set_time_seq: a 24h and a 12h instance share stimulus;
// table-driven full entries plus abort, held-button, re-entry and reset cases.
module tb_set_time_seq;

  logic       clk;
  logic       rst_n;
  logic [2:0] state;
  logic       nxt_but;
  logic [5:0] in_time;

  logic [5:0] sec24, min24, sec12, min12;
  logic [4:0] hr24, hr12;
  logic [1:0] fld24, fld12;
  logic       load24, load12, clp24, clp12;

  int n_checks = 0;
  int n_errors = 0;
  int load_cnt = 0;

  localparam logic [2:0] SET = 3'b010;

  set_time_seq #(.MODE_12H(1'b0)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .state(state), .nxt_but(nxt_but), .in_time(in_time),
    .seconds(sec24), .minutes(min24), .hours(hr24), .field(fld24),
    .load(load24), .clamped(clp24)
  );

  set_time_seq #(.MODE_12H(1'b1)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .state(state), .nxt_but(nxt_but), .in_time(in_time),
    .seconds(sec12), .minutes(min12), .hours(hr12), .field(fld12),
    .load(load12), .clamped(clp12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (load24 === 1'b1) load_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic [5:0] hr_in;
    int exp_sec;
    int exp_min;
    int exp_hr24;
    int exp_c24;
    int exp_hr12;
    int exp_c12;
  } vec_t;

  vec_t vecs[8];

  int pr_sec = 0, pr_min = 0, pr_hr24 = 0, pr_hr12 = 12;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  task automatic enter();
    state = SET;
    @(negedge clk);
  endtask

  // Drives one press; returns one edge later with the button already released.
  task automatic press(input logic [5:0] val);
    in_time = val;
    nxt_but = 1'b1;
    @(negedge clk);
    nxt_but = 1'b0;
  endtask

  initial begin
    int lc;
    vecs[0] = '{6'd7,  6'd8,  6'd9,  7,  8,  9,  0, 9,  0};
    vecs[1] = '{6'd63, 6'd60, 6'd30, 59, 59, 23, 1, 12, 1};
    vecs[2] = '{6'd0,  6'd0,  6'd0,  0,  0,  0,  0, 12, 1};
    vecs[3] = '{6'd10, 6'd20, 6'd13, 10, 20, 13, 0, 12, 1};
    vecs[4] = '{6'd59, 6'd59, 6'd23, 59, 59, 23, 0, 12, 1};
    vecs[5] = '{6'd1,  6'd2,  6'd5,  1,  2,  5,  0, 5,  0};
    vecs[6] = '{6'd58, 6'd0,  6'd24, 58, 0,  23, 1, 12, 1};
    vecs[7] = '{6'd0,  6'd59, 6'd12, 0,  59, 12, 0, 12, 0};

    rst_n = 1'b0; state = 3'b000; nxt_but = 1'b0; in_time = '0;
    repeat (2) @(negedge clk);
    check("rst seconds", sec24, 0);
    check("rst minutes", min24, 0);
    check("rst hours24", hr24, 0);
    check("rst hours12", hr12, 12);
    check("rst field", fld24, 3);
    check("rst load", load24, 0);
    check("rst clamped", clp24, 0);
    rst_n = 1'b1;
    idle_cycle();
    check("idle field", fld24, 3);

    for (int i = 0; i < 8; i++) begin
      state = 3'b000;
      idle_cycle();
      enter();
      check($sformatf("v%0d field sec", i), fld24, 0);
      press(vecs[i].sec_in);
      check($sformatf("v%0d field min", i), fld24, 1);
      check($sformatf("v%0d sec held", i), sec24, pr_sec);
      idle_cycle();
      press(vecs[i].min_in);
      check($sformatf("v%0d field hr", i), fld24, 2);
      check($sformatf("v%0d min held", i), min24, pr_min);
      idle_cycle();
      lc = load_cnt;
      press(vecs[i].hr_in);
      check($sformatf("v%0d load", i), load24, 1);
      check($sformatf("v%0d field idle", i), fld24, 3);
      check($sformatf("v%0d seconds", i), sec24, vecs[i].exp_sec);
      check($sformatf("v%0d minutes", i), min24, vecs[i].exp_min);
      check($sformatf("v%0d hours24", i), hr24, vecs[i].exp_hr24);
      check($sformatf("v%0d clamped24", i), clp24, vecs[i].exp_c24);
      check($sformatf("v%0d seconds12", i), sec12, vecs[i].exp_sec);
      check($sformatf("v%0d hours12", i), hr12, vecs[i].exp_hr12);
      check($sformatf("v%0d clamped12", i), clp12, vecs[i].exp_c12);
      state = 3'b000;
      idle_cycle();
      check($sformatf("v%0d load low", i), load24, 0);
      check($sformatf("v%0d one load", i), load_cnt - lc, 1);
      pr_sec = vecs[i].exp_sec; pr_min = vecs[i].exp_min;
      pr_hr24 = vecs[i].exp_hr24; pr_hr12 = vecs[i].exp_hr12;
    end

    // Abort from MIN: staging dropped, outputs kept, no load.
    lc = load_cnt;
    enter();
    press(6'd20);
    check("abort in MIN", fld24, 1);
    state = 3'b000;
    idle_cycle();
    check("abort field", fld24, 3);
    check("abort seconds", sec24, pr_sec);
    check("abort minutes", min24, pr_min);
    check("abort hours", hr24, pr_hr24);
    check("abort no load", load_cnt - lc, 0);

    // Held button: ten cycles high yields one advance.
    enter();
    in_time = 6'd33;
    nxt_but = 1'b1;
    repeat (10) @(negedge clk);
    nxt_but = 1'b0;
    check("held one advance", fld24, 1);
    idle_cycle();
    check("held still MIN", fld24, 1);

    // Press in the same cycle as leaving SET_STATE: abort wins.
    in_time = 6'd5;
    nxt_but = 1'b1;
    state = 3'b000;
    @(negedge clk);
    nxt_but = 1'b0;
    check("press+abort field", fld24, 3);
    check("press+abort minutes", min24, pr_min);
    check("press+abort no load", load_cnt - lc, 0);

    // Commit with state held: FSM re-enters SEC on the next cycle.
    idle_cycle();
    enter();
    press(6'd1); idle_cycle();
    press(6'd2); idle_cycle();
    press(6'd3);
    check("reentry load", load24, 1);
    check("reentry hours", hr24, 3);
    idle_cycle();
    check("reentry field", fld24, 0);
    check("reentry load low", load24, 0);

    // Async reset while in HR.
    press(6'd11); idle_cycle();
    press(6'd12); idle_cycle();
    check("pre-reset field hr", fld24, 2);
    lc = load_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("async seconds", sec24, 0);
    check("async minutes", min24, 0);
    check("async hours24", hr24, 0);
    check("async hours12", hr12, 12);
    check("async field", fld24, 3);
    check("async clamped", clp24, 0);
    @(negedge clk);
    state = 3'b000;
    rst_n = 1'b1;
    idle_cycle();
    press(6'd9);
    idle_cycle();
    check("post-reset field", fld24, 3);
    check("post-reset no load", load_cnt - lc, 0);
    check("post-reset seconds", sec24, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
